if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  IF stage directly downstream of the pre-IF PC generator. Takes the next PC,
//  issues it on the SRAM-like instruction bus, and buffers the returned
//  instruction until ID accepts it. Also drops stale responses after a flush.
//  Holds any redirect (br_taken/ex_en) until pre-IF has really consumed it.
// PARAMETERS
//  NOP_INST  32'h03400000  instruction word forwarded with an ADEF fault
//  ADEF_EN   1             1: misaligned PC raises ADEF without a bus request; 0: always request
// PORTS
//  clk              in   1   clock
//  reset            in   1   asynchronous, active-high reset
//  pre_valid        in   1   pre-IF has a valid next PC
//  pre_nextpc       in   32  next PC from pre-IF
//  if_allowin       out  1   next PC accepted this cycle; pre-IF updates its PC
//  flush            in   1   redirect request (branch or exception/ertn), one-cycle pulse
//  flush_target     in   32  redirect target
//  redir_valid      out  1   sticky redirect to pre-IF (drives its br_taken/ex_en mux)
//  redir_target     out  32  sticky redirect target
//  inst_sram_req    out  1   bus request
//  inst_sram_wr     out  1   tied 0
//  inst_sram_size   out  2   tied 2'b10
//  inst_sram_wstrb  out  4   tied 0
//  inst_sram_addr   out  32  request address (= pre_nextpc)
//  inst_sram_wdata  out  32  tied 0
//  inst_sram_addr_ok in  1   request accepted
//  inst_sram_data_ok in  1   read data returned
//  inst_sram_rdata  in   32  read data
//  id_allowin       in   1   ID can take an instruction
//  if_to_id_valid   out  1   instruction valid to ID
//  if_to_id_pc      out  32  instruction PC
//  if_to_id_inst    out  32  instruction word
//  if_to_id_adef    out  1   fetch-address fault
// BEHAVIOUR
//  - States: EMPTY, WAIT (address accepted, data pending), READY (word buffered), DISCARD (stale data pending).
//  - At most one outstanding request. Requests are issued only from EMPTY or READY.
//  - slot_free = EMPTY | (READY & (id_allowin | flush)); go = pre_valid & slot_free.
//  - mis = ADEF_EN & (pre_nextpc[1:0] != 0).
//  - inst_sram_req = go & ~mis. It never depends on addr_ok.
//  - inst_sram_addr = pre_nextpc.
//  - if_allowin = go & (mis | inst_sram_addr_ok).
//  - Accept with ~mis: next state WAIT; latch pc <= pre_nextpc; adef <= 0.
//  - Accept with mis: next state READY; pc <= pre_nextpc; inst <= NOP_INST; adef <= 1. No bus activity.
//  - WAIT & data_ok & ~flush -> READY; inst <= rdata.
//  - WAIT & flush & data_ok -> EMPTY; the data is dropped.
//  - WAIT & flush & ~data_ok -> DISCARD.
//  - DISCARD: the next data_ok is dropped, then -> EMPTY. A further flush stays in DISCARD and only updates the redirect.
//  - READY & (id_allowin | flush) & no accept -> EMPTY; an accept overrides this, as above.
//  - if_to_id_valid = READY & ~flush. pc, inst and adef stay stable while valid and not taken.
//  - Latency: addr_ok in cycle N, data_ok in cycle M>N -> if_to_id_valid at M+1. Back-to-back throughput is one instruction per 2 cycles.
//  - Redirect register: set, target <= flush_target, on flush & ~if_allowin; cleared on if_allowin.
//  - redir_valid = flush | pending.
//  - redir_target = flush ? flush_target : pending target.
//  - A newer flush overwrites the pending target.
//  - data_ok in EMPTY or READY is a protocol error; it is ignored.
//  - Reset (async): state EMPTY, redirect pending 0, pc/inst/adef 0; every output 0 except tied constants.
//  - Reset mid-transfer discards all state. The bus resets with the core.
// TESTING
//  1 Reset release; nextpc 0x1c000000; addr_ok in cycle 1; data_ok in cycle 2 with 0x02800c0c; id_allowin=1 -> valid in cycle 3, pc 0x1c000000, inst 0x02800c0c.
//  2 Word in READY; id_allowin=0 for 3 cycles -> req=0, if_allowin=0, outputs frozen; id_allowin=1 -> new req the same cycle.
//  3 Flush with target 0x1c000100 in WAIT; stale data_ok 2 cycles later -> dropped; redir_valid=1 until req for 0x1c000100 accepted.
//  4 Flush in the same cycle as data_ok in WAIT -> data dropped; EMPTY next; if_to_id_valid stays 0.
//  5 pre_nextpc 0x1c000002 -> no req; if_allowin=1; next cycle valid, adef=1, inst 0x03400000.
//  6 addr_ok low for 5 cycles -> req held 1, addr stable, if_allowin=0; pre-IF PC not advanced.

Source files
------------

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction-fetch stage between the pre-IF PC generator and ID.
//             Issues the next PC on an SRAM-like instruction bus, buffers the
//             returned word until ID takes it, drops responses made stale by a
//             flush, and holds redirects until pre-IF has consumed them.
//  Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] NOP_INST = 32'h03400000,
  parameter bit          ADEF_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,

  // pre-IF interface
  input  logic        pre_valid,
  input  logic [31:0] pre_nextpc,
  output logic        if_allowin,

  // redirect interface
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        redir_valid,
  output logic [31:0] redir_target,

  // instruction bus
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,

  // ID interface
  input  logic        id_allowin,
  output logic        if_to_id_valid,
  output logic [31:0] if_to_id_pc,
  output logic [31:0] if_to_id_inst,
  output logic        if_to_id_adef
);

  // EMPTY   : nothing held, nothing outstanding
  // WAIT    : address accepted, read data pending
  // READY   : instruction word buffered for ID
  // DISCARD : a flushed request still has its data in flight
  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_WAIT    = 2'd1,
    S_READY   = 2'd2,
    S_DISCARD = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        adef_q;

  logic        redir_pend_q;
  logic        redir_pend_d;
  logic [31:0] redir_tgt_q;
  logic [31:0] redir_tgt_d;

  logic        slot_free;
  logic        go;
  logic        mis;
  logic        accept;
  logic        out_en;

  // The buffer slot can take a new PC when empty, or when the buffered word
  // leaves this cycle (taken by ID or killed by a flush).
  assign slot_free = (state_q == S_EMPTY) ||
                     ((state_q == S_READY) && (id_allowin || flush));
  assign go        = pre_valid && slot_free;
  assign mis       = ADEF_EN && (pre_nextpc[1:0] != 2'b00);

  // A misaligned PC is consumed locally without touching the bus.
  assign accept    = go && (mis || inst_sram_addr_ok);

  // Keeps every non-constant output at zero while reset is asserted, even if
  // upstream inputs are not yet quiet.
  assign out_en    = !reset;

  // Bus request: combinational from the PC, never dependent on addr_ok.
  assign inst_sram_req   = out_en && go && !mis;
  assign inst_sram_addr  = out_en ? pre_nextpc : 32'h0;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;

  assign if_allowin      = out_en && accept;

  // A flush in the same cycle suppresses the buffered word towards ID.
  assign if_to_id_valid  = out_en && (state_q == S_READY) && !flush;
  assign if_to_id_pc     = pc_q;
  assign if_to_id_inst   = inst_q;
  assign if_to_id_adef   = adef_q;

  // A live flush is forwarded immediately; otherwise the held redirect is.
  assign redir_valid     = out_en && (flush || redir_pend_q);
  assign redir_target    = !out_en ? 32'h0 :
                           flush   ? flush_target : redir_tgt_q;

  // Fetch FSM together with the buffered pc/inst/adef it owns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
      pc_q    <= 32'h0;
      inst_q  <= 32'h0;
      adef_q  <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY, S_READY: begin
          if (accept) begin
            pc_q   <= pre_nextpc;
            adef_q <= mis;
            if (mis) begin
              inst_q  <= NOP_INST;
              state_q <= S_READY;
            end else begin
              state_q <= S_WAIT;
            end
          end else if (state_q == S_READY && (id_allowin || flush)) begin
            state_q <= S_EMPTY;
          end
          // data_ok here is a protocol violation and is simply ignored.
        end

        S_WAIT: begin
          if (flush) begin
            // Data arriving with the flush is dropped on the spot; otherwise
            // it is still in flight and must be swallowed later.
            state_q <= inst_sram_data_ok ? S_EMPTY : S_DISCARD;
          end else if (inst_sram_data_ok) begin
            inst_q  <= inst_sram_rdata;
            state_q <= S_READY;
          end
        end

        S_DISCARD: begin
          if (inst_sram_data_ok) begin
            state_q <= S_EMPTY;
          end
        end

        default: state_q <= S_EMPTY;
      endcase
    end
  end

  // Redirect hold: captured when pre-IF cannot consume it this cycle,
  // released once pre-IF actually advances its PC.
  always_comb begin
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    if (accept) begin
      redir_pend_d = 1'b0;
    end else if (flush) begin
      redir_pend_d = 1'b1;
      redir_tgt_d  = flush_target;
    end
  end

  // Redirect state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= 32'h0;
    end else begin
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Directed self-checking bench for if_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        pre_valid;
  logic [31:0] pre_nextpc;
  logic        if_allowin;
  logic        flush;
  logic [31:0] flush_target;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        id_allowin;
  logic        if_to_id_valid;
  logic [31:0] if_to_id_pc;
  logic [31:0] if_to_id_inst;
  logic        if_to_id_adef;

  int n_cmp;
  int n_bad;

  if_stage dut (
    .clk               (clk),
    .reset             (reset),
    .pre_valid         (pre_valid),
    .pre_nextpc        (pre_nextpc),
    .if_allowin        (if_allowin),
    .flush             (flush),
    .flush_target      (flush_target),
    .redir_valid       (redir_valid),
    .redir_target      (redir_target),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .id_allowin        (id_allowin),
    .if_to_id_valid    (if_to_id_valid),
    .if_to_id_pc       (if_to_id_pc),
    .if_to_id_inst     (if_to_id_inst),
    .if_to_id_adef     (if_to_id_adef)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset             = 1'b1;
    pre_valid         = 1'b0;
    pre_nextpc        = 32'h0;
    flush             = 1'b0;
    flush_target      = 32'h0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'h0;
    id_allowin        = 1'b0;

    // ---------------- reset state ----------------
    #2;
    chk("rst_req",    {31'h0, inst_sram_req},   32'h0);
    chk("rst_allow",  {31'h0, if_allowin},      32'h0);
    chk("rst_valid",  {31'h0, if_to_id_valid},  32'h0);
    chk("rst_redir",  {31'h0, redir_valid},     32'h0);
    chk("rst_pc",     if_to_id_pc,              32'h0);
    chk("rst_size",   {30'h0, inst_sram_size},  32'h2);
    chk("rst_wr",     {31'h0, inst_sram_wr},    32'h0);
    tick();
    reset = 1'b0;

    // ---------------- test 1: basic fetch ----------------
    pre_valid = 1'b1; pre_nextpc = 32'h1c000000; inst_sram_addr_ok = 1'b1; id_allowin = 1'b1;
    #3;
    chk("t1_req",   {31'h0, inst_sram_req}, 32'h1);
    chk("t1_addr",  inst_sram_addr,         32'h1c000000);
    chk("t1_allow", {31'h0, if_allowin},    32'h1);
    tick();
    pre_nextpc = 32'h1c000004; inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h02800c0c;
    #3;
    chk("t1_wait_req",   {31'h0, inst_sram_req},  32'h0);
    chk("t1_wait_valid", {31'h0, if_to_id_valid}, 32'h0);
    tick();
    inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
    // ---------------- test 2: ID stall while READY ----------------
    id_allowin = 1'b0; inst_sram_addr_ok = 1'b1;
    #3;
    chk("t1_valid", {31'h0, if_to_id_valid}, 32'h1);
    chk("t1_pc",    if_to_id_pc,             32'h1c000000);
    chk("t1_inst",  if_to_id_inst,           32'h02800c0c);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) #3;
      chk("t2_req",   {31'h0, inst_sram_req},  32'h0);
      chk("t2_allow", {31'h0, if_allowin},     32'h0);
      chk("t2_valid", {31'h0, if_to_id_valid}, 32'h1);
      chk("t2_pc",    if_to_id_pc,             32'h1c000000);
      chk("t2_inst",  if_to_id_inst,           32'h02800c0c);
      tick();
    end
    id_allowin = 1'b1;
    #3;
    chk("t2_go_req",   {31'h0, inst_sram_req}, 32'h1);
    chk("t2_go_addr",  inst_sram_addr,         32'h1c000004);
    chk("t2_go_allow", {31'h0, if_allowin},    32'h1);
    tick();

    // ---------------- test 3: flush in WAIT, stale data later ----------------
    inst_sram_addr_ok = 1'b0; flush = 1'b1; flush_target = 32'h1c000100;
    pre_nextpc = 32'h1c000100;
    #3;
    chk("t3_redir",   {31'h0, redir_valid}, 32'h1);
    chk("t3_tgt",     redir_target,         32'h1c000100);
    chk("t3_req",     {31'h0, inst_sram_req}, 32'h0);
    tick();
    flush = 1'b0; flush_target = 32'h0;
    #3;
    chk("t3_pend",     {31'h0, redir_valid}, 32'h1);
    chk("t3_pend_tgt", redir_target,         32'h1c000100);
    chk("t3_disc_req", {31'h0, inst_sram_req}, 32'h0);
    tick();
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hdeadbeef;
    #3;
    chk("t3_stale_valid", {31'h0, if_to_id_valid}, 32'h0);
    chk("t3_stale_req",   {31'h0, inst_sram_req},  32'h0);
    tick();
    inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
    #3;
    chk("t3_drop_valid", {31'h0, if_to_id_valid}, 32'h0);
    chk("t3_rq",         {31'h0, inst_sram_req},  32'h1);
    chk("t3_rq_addr",    inst_sram_addr,          32'h1c000100);
    chk("t3_rq_allow",   {31'h0, if_allowin},     32'h0);
    chk("t3_rq_redir",   {31'h0, redir_valid},    32'h1);
    tick();
    inst_sram_addr_ok = 1'b1;
    #3;
    chk("t3_acc_allow", {31'h0, if_allowin},  32'h1);
    chk("t3_acc_redir", {31'h0, redir_valid}, 32'h1);
    tick();

    // ---------------- test 4: flush together with data_ok ----------------
    inst_sram_addr_ok = 1'b0; pre_nextpc = 32'h1c000104;
    #1;
    chk("t3_redir_clr", {31'h0, redir_valid}, 32'h0);
    flush = 1'b1; flush_target = 32'h1c000200;
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h11111111;
    #2;
    chk("t4_valid", {31'h0, if_to_id_valid}, 32'h0);
    chk("t4_redir", {31'h0, redir_valid},    32'h1);
    tick();
    flush = 1'b0; flush_target = 32'h0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
    pre_valid = 1'b0;
    #3;
    chk("t4_empty_valid", {31'h0, if_to_id_valid}, 32'h0);
    chk("t4_empty_req",   {31'h0, inst_sram_req},  32'h0);
    chk("t4_pend_tgt",    redir_target,            32'h1c000200);
    tick();

    // ---------------- test 5: misaligned PC -> ADEF ----------------
    pre_valid = 1'b1; pre_nextpc = 32'h1c000002;
    #3;
    chk("t5_req",   {31'h0, inst_sram_req}, 32'h0);
    chk("t5_allow", {31'h0, if_allowin},    32'h1);
    tick();
    pre_valid = 1'b0; id_allowin = 1'b0;
    #3;
    chk("t5_valid", {31'h0, if_to_id_valid}, 32'h1);
    chk("t5_adef",  {31'h0, if_to_id_adef},  32'h1);
    chk("t5_inst",  if_to_id_inst,           32'h03400000);
    chk("t5_pc",    if_to_id_pc,             32'h1c000002);
    chk("t5_redir", {31'h0, redir_valid},    32'h0);
    tick();
    id_allowin = 1'b1;
    tick();

    // ---------------- test 6: addr_ok held low ----------------
    pre_valid = 1'b1; pre_nextpc = 32'h1c000200; inst_sram_addr_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("t6_req",   {31'h0, inst_sram_req}, 32'h1);
      chk("t6_addr",  inst_sram_addr,         32'h1c000200);
      chk("t6_allow", {31'h0, if_allowin},    32'h0);
      tick();
    end
    inst_sram_addr_ok = 1'b1;
    #3;
    chk("t6_acc_allow", {31'h0, if_allowin}, 32'h1);
    tick();
    inst_sram_addr_ok = 1'b0; pre_valid = 1'b0;
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h0badf00d;
    tick();
    inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0; id_allowin = 1'b0;
    #3;
    chk("t6_valid", {31'h0, if_to_id_valid}, 32'h1);
    chk("t6_inst",  if_to_id_inst,           32'h0badf00d);
    chk("t6_pc",    if_to_id_pc,             32'h1c000200);
    chk("t6_adef",  {31'h0, if_to_id_adef},  32'h0);

    // ---------------- asynchronous reset mid-operation ----------------
    reset = 1'b1;
    #1;
    chk("ar_valid", {31'h0, if_to_id_valid}, 32'h0);
    chk("ar_pc",    if_to_id_pc,             32'h0);
    chk("ar_inst",  if_to_id_inst,           32'h0);
    tick();
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
